sampq_arbiter: RTL and testbench
================================

# sampq_arbiter

Round-robin arbiter that shares the sample queue's single write port between NUM_SOURCES sample producers. Each source has a one-entry holding slot. The arbiter grants slots fairly into a registered valid/ready output stage facing the sample queue, and tracks per-source overflows. It sits between the capture/measurement units and the sample queue write side, and is gated by the queue's sq_active enable.

## Interface
- NUM_SOURCES, 4: number of requesters, range 2..16.
- SAMPLE_W, 72: width of one sample.
- clk  in  1  the single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sq_active  in  1  queue enabled; when low, all pending samples are flushed.
- sources  in  SAMPLE_W*NUM_SOURCES  per-source sample data; source i occupies bits [i*SAMPLE_W +: SAMPLE_W].
- avails  in  NUM_SOURCES  single-cycle strobe; source i presents a new sample this cycle.
- sample  out  SAMPLE_W  registered sample toward the queue.
- sample_avail  out  1  sample is valid.
- sample_ready  in  1  queue accepts sample this cycle.
- sample_src  out  $clog2(NUM_SOURCES)  index of the source that produced `sample`.
- overflow  out  NUM_SOURCES  sticky per-source flag: a sample was dropped.
- drop_count  out  16  total dropped samples, saturating.

## Operation
- Reset behaviour: have_data=0, sample_avail=0, sample=0, sample_src=0, overflow=0, drop_count=0, grant pointer=NUM_SOURCES-1, so source 0 has first priority.
- Holding slots:
  - avails[i] with slot i empty stores sources[i] and sets have_data[i].
  - avails[i] with slot i full and not granted this cycle drops the new sample and keeps the old one.
  - A drop sets overflow[i] and increments drop_count, saturating at 0xFFFF.
  - Several simultaneous drops in one cycle add their count, still saturating.
- Slot drain and refill in the same cycle: if avails[i] arrives while slot i is being granted, the slot is refilled with the new sample. This is not an overflow.
- Output stage load condition: `load = !sample_avail || sample_ready`.
- On load, the arbiter searches have_data starting at index (ptr+1) mod NUM_SOURCES, wrapping around. The first set slot k is granted:
  - sample ← slot k
  - sample_src ← k
  - sample_avail ← 1
  - have_data[k] cleared
  - ptr ← k
- If nothing is pending on load, sample_avail ← 0. sample and sample_src hold their previous values.
- Valid/ready hold rule: while sample_avail=1 and sample_ready=0, sample and sample_src must stay stable.
- sq_active low, evaluated every cycle and overriding everything above:
  - have_data and sample_avail clear on the next edge.
  - overflow and drop_count clear.
  - ptr ← NUM_SOURCES-1.
  - avails is ignored and never counts as an overflow.
- sq_active is not edge-detected. Flushing is level behaviour.

## Timing
- Latency: avails[i] at edge E0 fills the slot, and sample_avail is high after edge E1 if the output stage can load at E1. Minimum latency is 2 cycles.
- Throughput: one sample per cycle when sample_ready stays high and slots are pending.
- A transfer completes on an edge where sample_avail && sample_ready. The next granted sample appears on that same edge, with no bubble.
- Fairness: with all slots continuously full and sample_ready=1, grants follow the sequence 0,1,…,N-1,0,…. A source waits at most NUM_SOURCES-1 grants.
- Reset mid-operation: rst_n low forces all outputs to their reset values immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- Arbitration search is combinational over NUM_SOURCES. There is no added pipeline stage.

## Test plan
- Reset then single sample: rst_n released, sq_active=1, avails=0001 with sources[0]=0x11 at E0 → sample_avail=1, sample=0x11, sample_src=0 after E1. With sample_ready=1 it drops to 0 after E2.
- Round-robin fairness: avails=1111 every cycle with data i*0x10+cycle, sample_ready=1 → sample_src sequence 0,1,2,3,0,1,… from the first grant onward. Some sources drop samples: overflow bits set, drop_count increments per drop.
- Backpressure hold: fill slots 1 and 2, hold sample_ready=0 for 5 cycles → sample and sample_src unchanged for all 5 cycles, overflow=0. Release → source 1 then source 2 on consecutive edges.
- Overflow vs. refill: slot 3 full and output stalled, avails[3] again → overflow[3]=1, drop_count=1, and the original data is the one delivered. Repeat with slot 3 granted on the same edge as avails[3] → no overflow, and the new data is delivered next.
- Flush: slots 0–3 full, sample_avail=1, drop_count=5, then sq_active=0 for 1 cycle with avails=1111 → after the edge have_data=0, sample_avail=0, overflow=0, drop_count=0. After sq_active=1, the first grant is source 0.
- Saturation: force 70000 drops → drop_count stops at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/sampq_arbiter.sv
// Round-robin arbiter: one holding slot per source, granted into a registered valid/ready stage.
// Latency 2 cycles from avails to sample_avail; output holds while stalled, full slots drop new samples.
module sampq_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int SAMPLE_W    = 72
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sq_active,
  input  logic [SAMPLE_W*NUM_SOURCES-1:0] sources,
  input  logic [NUM_SOURCES-1:0]          avails,
  output logic [SAMPLE_W-1:0]             sample,
  output logic                            sample_avail,
  input  logic                            sample_ready,
  output logic [$clog2(NUM_SOURCES)-1:0]  sample_src,
  output logic [NUM_SOURCES-1:0]          overflow,
  output logic [15:0]                     drop_count
);

  localparam int PW = $clog2(NUM_SOURCES);

  logic [NUM_SOURCES-1:0] have_data;
  logic [SAMPLE_W-1:0]    slot [NUM_SOURCES];
  logic [PW-1:0]          ptr;

  logic                   load;
  logic                   found;
  logic [PW-1:0]          grant_idx;
  logic [NUM_SOURCES-1:0] grant_oh;
  logic [NUM_SOURCES-1:0] fill;
  logic [NUM_SOURCES-1:0] drop_mask;
  logic [4:0]             drop_num;
  logic [16:0]            drop_sum;
  int                     idx;

  assign load = !sample_avail || sample_ready;

  // Search starts just after the last granted source and wraps.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int o = 1; o <= NUM_SOURCES; o++) begin
      idx = int'(ptr) + o;
      if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
      if (!found && have_data[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    grant_oh  = '0;
    fill      = '0;
    drop_mask = '0;
    drop_num  = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      grant_oh[i]  = load && found && (grant_idx == PW'(i));
      // A slot being drained this cycle may take a new sample without dropping.
      fill[i]      = sq_active && avails[i] && (!have_data[i] || grant_oh[i]);
      drop_mask[i] = sq_active && avails[i] && have_data[i] && !grant_oh[i];
      drop_num     = drop_num + {4'b0, drop_mask[i]};
    end
    drop_sum = {1'b0, drop_count} + {12'b0, drop_num};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_data <= '0;
      for (int i = 0; i < NUM_SOURCES; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (fill[i]) slot[i] <= sources[i*SAMPLE_W +: SAMPLE_W];
        if (!sq_active)      have_data[i] <= 1'b0;
        else if (fill[i])    have_data[i] <= 1'b1;
        else if (grant_oh[i]) have_data[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_src   <= '0;
      sample_avail <= 1'b0;
      ptr          <= PW'(NUM_SOURCES - 1);
      overflow     <= '0;
      drop_count   <= '0;
    end else if (!sq_active) begin
      sample_avail <= 1'b0;
      ptr          <= PW'(NUM_SOURCES - 1);
      overflow     <= '0;
      drop_count   <= '0;
    end else begin
      if (load) begin
        if (found) begin
          sample       <= slot[grant_idx];
          sample_src   <= grant_idx;
          sample_avail <= 1'b1;
          ptr          <= grant_idx;
        end else begin
          sample_avail <= 1'b0;
        end
      end
      overflow   <= overflow | drop_mask;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_sampq_arbiter.sv
// Randomised and directed bench for sampq_arbiter with a queue-level reference model.
module tb_sampq_arbiter;

  localparam int N  = 4;
  localparam int SW = 72;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sq_active;
  logic [SW*N-1:0] sources;
  logic [N-1:0]    avails;
  logic [SW-1:0]   sample;
  logic            sample_avail;
  logic            sample_ready;
  logic [PW-1:0]   sample_src;
  logic [N-1:0]    overflow;
  logic [15:0]     drop_count;

  always #5 clk = ~clk;

  sampq_arbiter #(.NUM_SOURCES(N), .SAMPLE_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sq_active    (sq_active),
    .sources      (sources),
    .avails       (avails),
    .sample       (sample),
    .sample_avail (sample_avail),
    .sample_ready (sample_ready),
    .sample_src   (sample_src),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [SW-1:0] src_dat [N];

  // Reference model state
  bit            m_have [N];
  logic [SW-1:0] m_slot [N];
  int            m_ptr;
  bit            m_vld;
  logic [SW-1:0] m_dat;
  int            m_src;
  logic [N-1:0]  m_ovf;
  int            m_drops;

  int seq[$];

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_have[i] = 1'b0;
      m_slot[i] = '0;
    end
    m_ptr = N - 1; m_vld = 1'b0; m_dat = '0; m_src = 0; m_ovf = '0; m_drops = 0;
  endtask

  task automatic model_step();
    int g;
    bit ld;
    if (!sq_active) begin
      for (int i = 0; i < N; i++) m_have[i] = 1'b0;
      m_vld = 1'b0; m_ovf = '0; m_drops = 0; m_ptr = N - 1;
      return;
    end
    g  = -1;
    ld = !m_vld || sample_ready;
    if (ld) begin
      for (int o = 1; o <= N; o++) begin
        int k = (m_ptr + o) % N;
        if (g < 0 && m_have[k]) g = k;
      end
      if (g >= 0) begin
        m_dat = m_slot[g]; m_src = g; m_vld = 1'b1; m_ptr = g; m_have[g] = 1'b0;
      end else begin
        m_vld = 1'b0;
      end
    end
    // Granted slot is already emptied above, so it refills instead of dropping.
    for (int i = 0; i < N; i++) begin
      if (avails[i]) begin
        if (m_have[i]) begin
          m_ovf[i] = 1'b1;
          if (m_drops < 65535) m_drops++;
        end else begin
          m_slot[i] = src_dat[i];
          m_have[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [PW-1:0]  es;
    logic [15:0]    ed;
    es = PW'(m_src);
    ed = 16'(m_drops);
    check("sample_avail", SW'(sample_avail), SW'(m_vld));
    check("sample",       sample,            m_dat);
    check("sample_src",   SW'(sample_src),   SW'(es));
    check("overflow",     SW'(overflow),     SW'(m_ovf));
    check("drop_count",   SW'(drop_count),   SW'(ed));
  endtask

  task automatic tick();
    for (int i = 0; i < N; i++) sources[i*SW +: SW] = src_dat[i];
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [N-1:0] av, input logic rdy, input logic sq, input int base);
    avails = av; sample_ready = rdy; sq_active = sq;
    for (int i = 0; i < N; i++) src_dat[i] = SW'(base + i * 16);
  endtask

  task automatic flush();
    drive(4'b0000, 1'b1, 1'b0, 0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 0);
    for (int i = 0; i < N; i++) sources[i*SW +: SW] = src_dat[i];
    #3;
    check("rst_sample_avail", SW'(sample_avail), '0);
    check("rst_sample",       sample,            '0);
    check("rst_sample_src",   SW'(sample_src),   '0);
    check("rst_overflow",     SW'(overflow),     '0);
    check("rst_drop_count",   SW'(drop_count),   '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Single sample through an empty arbiter
    drive(4'b0001, 1'b1, 1'b1, 0);
    src_dat[0] = SW'(72'h11);
    tick();
    check("single_not_yet", SW'(sample_avail), '0);
    avails = '0;
    tick();
    check("single_avail", SW'(sample_avail), SW'(1));
    check("single_data",  sample,            SW'(72'h11));
    check("single_src",   SW'(sample_src),   '0);
    tick();
    check("single_drain", SW'(sample_avail), '0);

    // Round-robin with every source requesting each cycle
    flush();
    seq.delete();
    for (int c = 0; c < 12; c++) begin
      drive(4'b1111, 1'b1, 1'b1, c);
      tick();
      if (sample_avail) seq.push_back(int'(sample_src));
    end
    for (int j = 0; j < 8; j++) check("rr_seq", SW'(seq[j]), SW'(j % 4));
    check("rr_overflow", SW'(overflow),   SW'(4'hF));
    check("rr_drops",    SW'(drop_count), SW'(33));

    // Backpressure hold
    flush();
    drive(4'b0110, 1'b0, 1'b1, 0);
    src_dat[1] = SW'(72'hA1); src_dat[2] = SW'(72'hA2);
    tick();
    avails = '0;
    tick();
    check("bp_first_src", SW'(sample_src), SW'(1));
    repeat (5) begin
      tick();
      check("bp_hold_src",  SW'(sample_src), SW'(1));
      check("bp_hold_data", sample,          SW'(72'hA1));
      check("bp_hold_ovf",  SW'(overflow),   '0);
    end
    sample_ready = 1'b1;
    tick();
    check("bp_next_src",  SW'(sample_src), SW'(2));
    check("bp_next_data", sample,          SW'(72'hA2));
    tick();
    check("bp_empty", SW'(sample_avail), '0);

    // Overflow versus same-cycle refill on slot 3
    flush();
    drive(4'b1000, 1'b0, 1'b1, 0); src_dat[3] = SW'(72'hB0); tick();
    avails = '0; tick();
    avails = 4'b1000; src_dat[3] = SW'(72'hB1); tick();
    src_dat[3] = SW'(72'hB2); tick();
    check("ovf_flag",  SW'(overflow),   SW'(4'b1000));
    check("ovf_count", SW'(drop_count), SW'(1));
    avails = '0; sample_ready = 1'b1; tick();
    check("ovf_keeps_old", sample,          SW'(72'hB1));
    check("ovf_src",       SW'(sample_src), SW'(3));
    avails = 4'b1000; sample_ready = 1'b0; src_dat[3] = SW'(72'hB3); tick();
    sample_ready = 1'b1; src_dat[3] = SW'(72'hB4); tick();
    check("refill_grant", sample,          SW'(72'hB3));
    check("refill_count", SW'(drop_count), SW'(1));
    avails = '0; tick();
    check("refill_new", sample, SW'(72'hB4));

    // Flush with full slots and pending drops
    flush();
    drive(4'b1111, 1'b0, 1'b1, 8'hC0); tick();
    avails = 4'b1110; tick();
    avails = 4'b0111; tick();
    check("pre_flush_drops", SW'(drop_count),   SW'(5));
    check("pre_flush_avail", SW'(sample_avail), SW'(1));
    drive(4'b1111, 1'b0, 1'b0, 8'hD0); tick();
    check("flush_avail", SW'(sample_avail), '0);
    check("flush_ovf",   SW'(overflow),     '0);
    check("flush_drops", SW'(drop_count),   '0);
    drive(4'b1111, 1'b1, 1'b1, 8'hE0); tick();
    avails = '0; tick();
    check("post_flush_src",   SW'(sample_src),   '0);
    check("post_flush_avail", SW'(sample_avail), SW'(1));

    // Randomised traffic, with one asynchronous reset mid-run
    for (int c = 0; c < 3000; c++) begin
      avails       = N'($urandom_range(0, 15));
      sample_ready = ($urandom_range(0, 3) != 0);
      sq_active    = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < N; i++) src_dat[i] = {8'($urandom), $urandom, $urandom};
      tick();
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_avail", SW'(sample_avail), '0);
        check("async_rst_data",  sample,            '0);
        check("async_rst_src",   SW'(sample_src),   '0);
        check("async_rst_ovf",   SW'(overflow),     '0);
        check("async_rst_drops", SW'(drop_count),   '0);
        model_reset();
        rst_n = 1'b1;
      end
    end

    // Drop counter saturation
    flush();
    drive(4'b1111, 1'b0, 1'b1, 0);
    repeat (17600) tick();
    check("sat_drops", SW'(drop_count), SW'(16'hFFFF));
    check("sat_ovf",   SW'(overflow),   SW'(4'hF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
